// File: rtl/priority_encoder_drain.sv
// Registered multi-hot priority encoder: accepts a request vector, then drains its set bits one index per handshake.
// Define ENC_MSB_FIRST_EN to drain highest index first instead of lowest.
module priority_encoder_drain #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             empty_drop
);

    if ((2 ** OUT_W) < WIDTH) begin : g_bad_out_w
        $error("priority_encoder_drain: OUT_W too small for WIDTH");
    end
    if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
        $error("priority_encoder_drain: WIDTH outside 2..256");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             empty_drop_q, empty_drop_d;

    function automatic logic [OUT_W-1:0] pick(input logic [WIDTH-1:0] v);
        logic [OUT_W-1:0] r;
        r = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = OUT_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = OUT_W'(i);
        end
`endif
        return r;
    endfunction

    logic accept;
    logic fire;
    logic one_hot;

    // Index and last flag depend only on registered pend, so they hold under backpressure.
    always_comb begin
        out_idx   = pick(pend_q);
        one_hot   = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);
        out_last  = one_hot;
        out_valid = (state_q == DRAIN);
        busy      = (state_q == DRAIN);
        fire      = out_valid & out_ready;
        in_ready  = (state_q == IDLE) | (fire & out_last);
        accept    = in_valid & in_ready;
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        empty_drop_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_vec != '0) begin
                        pend_d  = in_vec;
                        state_d = DRAIN;
                    end else begin
                        empty_drop_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fire && !out_last) begin
                    pend_d = pend_q & ~(WIDTH'(1) << out_idx);
                end else if (fire && out_last) begin
                    // Final handshake may reload directly, avoiding an idle bubble.
                    if (accept && in_vec != '0) begin
                        pend_d = in_vec;
                    end else begin
                        pend_d       = '0;
                        state_d      = IDLE;
                        empty_drop_d = accept;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            empty_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            empty_drop_q <= empty_drop_d;
        end
    end

    assign empty_drop = empty_drop_q;

endmodule

// File: tb/tb_priority_encoder_drain.sv
// Directed bench for priority_encoder_drain with a queue-based reference model.
module tb_priority_encoder_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        empty_drop;

    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic [4:0]  in_vec5 = '0;
    logic        out_valid5;
    logic        out_ready5 = 1'b1;
    logic [2:0]  out_idx5;
    logic        out_last5;
    logic        busy5;
    logic        empty_drop5;

    int total = 0;
    int bad = 0;

    int model_q[$];
    bit drop_exp = 1'b0;
    int log_idx[$];
    int log_last[$];

    always #5 clk = ~clk;

    priority_encoder_drain u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .empty_drop(empty_drop)
    );

    priority_encoder_drain #(.WIDTH(5), .OUT_W(3)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_vec(in_vec5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .out_idx(out_idx5), .out_last(out_last5),
        .busy(busy5), .empty_drop(empty_drop5)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_last.delete();
    endtask

    // Reference model: the pending set is just an ordered list of indices.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_q.delete();
                drop_exp = 1'b0;
            end else begin
                bit rdy;
                bit dn;
                rdy = (model_q.size() == 0) ||
                      (out_ready && model_q.size() == 1);
                dn = 1'b0;
                if (model_q.size() > 0 && out_ready)
                    void'(model_q.pop_front());
                if (in_valid && rdy) begin
                    if (in_vec == 16'h0) dn = 1'b1;
`ifdef ENC_MSB_FIRST_EN
                    for (int i = 15; i >= 0; i--)
                        if (in_vec[i]) model_q.push_back(i);
`else
                    for (int i = 0; i < 16; i++)
                        if (in_vec[i]) model_q.push_back(i);
`endif
                end
                drop_exp = dn;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                int n;
                n = model_q.size();
                chk("out_valid", int'(out_valid), int'(n > 0));
                chk("busy", int'(busy), int'(n > 0));
                chk("in_ready", int'(in_ready),
                    int'(n == 0 || (out_ready && n == 1)));
                chk("empty_drop", int'(empty_drop), int'(drop_exp));
                chk("out_last", int'(out_last), int'(n == 1));
                if (n > 0) chk("out_idx", int'(out_idx), model_q[0]);
                if (out_valid && out_ready) begin
                    log_idx.push_back(int'(out_idx));
                    log_last.push_back(int'(out_last));
                end
            end
        end
    end

    initial begin
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_empty_drop", int'(empty_drop), 0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1;
            in_vec = 16'h1 << n;
            step();
            in_valid = 1'b0;
            chk("onehot_idx", int'(out_idx), n);
            chk("onehot_last", int'(out_last), 1);
            chk("onehot_valid", int'(out_valid), 1);
            step();
        end

        clear_log();
        in_valid = 1'b1;
        in_vec = 16'b1000_0100_0001_0010;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("multi_len", log_idx.size(), 4);
        if (log_idx.size() == 4) begin
`ifdef ENC_MSB_FIRST_EN
            chk("multi_0", log_idx[0], 15);
            chk("multi_1", log_idx[1], 10);
            chk("multi_2", log_idx[2], 4);
            chk("multi_3", log_idx[3], 1);
`else
            chk("multi_0", log_idx[0], 1);
            chk("multi_1", log_idx[1], 4);
            chk("multi_2", log_idx[2], 10);
            chk("multi_3", log_idx[3], 15);
`endif
            chk("multi_last0", log_last[0], 0);
            chk("multi_last2", log_last[2], 0);
            chk("multi_last3", log_last[3], 1);
        end

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_vec = 16'h0003;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
`ifdef ENC_MSB_FIRST_EN
            chk("bp_idx", int'(out_idx), 1);
`else
            chk("bp_idx", int'(out_idx), 0);
`endif
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
            in_vec = 16'hFFFF;
            step();
        end
        clear_log();
        out_ready = 1'b1;
        repeat (3) step();
        chk("bp_len", log_idx.size(), 2);
        if (log_idx.size() == 2) begin
`ifdef ENC_MSB_FIRST_EN
            chk("bp_first", log_idx[0], 1);
            chk("bp_second", log_idx[1], 0);
`else
            chk("bp_first", log_idx[0], 0);
            chk("bp_second", log_idx[1], 1);
`endif
            chk("bp_last", log_last[1], 1);
        end

        in_valid = 1'b1;
        in_vec = 16'h0000;
        step();
        in_valid = 1'b0;
        chk("zero_drop", int'(empty_drop), 1);
        chk("zero_valid", int'(out_valid), 0);
        step();
        chk("zero_drop_gone", int'(empty_drop), 0);

        clear_log();
        in_valid = 1'b1;
        in_vec = 16'h0100;
        step();
        in_vec = 16'h8000;
        chk("b2b_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_idx", int'(out_idx), 15);
        step();
        step();
        chk("b2b_len", log_idx.size(), 2);
        if (log_idx.size() == 2) begin
            chk("b2b_first", log_idx[0], 8);
            chk("b2b_second", log_idx[1], 15);
        end

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_vec = 16'h00F0;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        clear_log();
        repeat (4) step();
        chk("post_rst_quiet", log_idx.size(), 0);

        in_valid5 = 1'b1;
        in_vec5 = 5'b10101;
        step();
        in_valid5 = 1'b0;
        for (int k = 0; k < 3; k++) begin
`ifdef ENC_MSB_FIRST_EN
            chk("w5_idx", int'(out_idx5), 4 - 2 * k);
`else
            chk("w5_idx", int'(out_idx5), 2 * k);
`endif
            chk("w5_last", int'(out_last5), int'(k == 2));
            chk("w5_valid", int'(out_valid5), 1);
            step();
        end
        chk("w5_done", int'(out_valid5), 0);
        chk("w5_ready", int'(in_ready5), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
